// File: rtl/if_id_queue_pkg.sv
// Shared IF/ID pipeline definitions: default widths, the NOP bubble word,
// occupancy states and the occupancy-counter width helper.
package if_id_queue_pkg;

   localparam int DATA_W_DEF = 32;

   // All-zero word driven to ID when the queue is empty.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Occupancy classification of the queue, derived from the counter.
   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_state_t;

   // Width needed to hold an occupancy of 0..depth inclusive.
   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/if_id_storage.sv
// Register array for the IF/ID queue: one synchronous write port,
// one asynchronous read port and a synchronous active-low clear.
module if_id_storage
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = DATA_W_DEF,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [PTR_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_pc,
   input  logic [DATA_W-1:0] wr_instr,
   input  logic [PTR_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_pc,
   output logic [DATA_W-1:0] rd_instr
);

   logic [DATA_W-1:0] pc_mem    [DEPTH];
   logic [DATA_W-1:0] instr_mem [DEPTH];

   // Clear every entry on reset, otherwise write one pair when enabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (wr_en) begin
         pc_mem[wr_addr]    <= wr_pc;
         instr_mem[wr_addr] <= wr_instr;
      end
   end

   // Asynchronous read of the addressed entry.
   always_comb begin
      rd_pc    = pc_mem[rd_addr];
      rd_instr = instr_mem[rd_addr];
   end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: holds up to DEPTH {PC, instruction} pairs in FIFO
// order, back-pressures IF via in_ready and empties on a taken-branch flush.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [DATA_W-1:0]           in_pc,
   input  logic [DATA_W-1:0]           in_instr,
   output logic                        in_ready,
   input  logic                        flush,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_pc,
   output logic [DATA_W-1:0]           out_instr,
   input  logic                        out_ready,
   output logic [count_w(DEPTH)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_w(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] rd_pc;
   logic [DATA_W-1:0] rd_instr;
   logic              push;
   logic              pop;
   occ_state_t        occ;

   // Classify occupancy; handshakes depend only on registered count,
   // so in_ready has no combinational path from out_ready.
   always_comb begin
      occ = OCC_PARTIAL;
      if (count == '0)
         occ = OCC_EMPTY;
      else if (count == FULL_CNT)
         occ = OCC_FULL;
      in_ready  = (occ != OCC_FULL);
      out_valid = (occ != OCC_EMPTY);
      push      = in_valid  && in_ready  && !flush;
      pop       = out_valid && out_ready && !flush;
   end

   // Pointer and occupancy update; flush empties, reset overrides all.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   if_id_storage #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W)
   ) u_storage (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (push),
      .wr_addr  (wr_ptr),
      .wr_pc    (in_pc),
      .wr_instr (in_instr),
      .rd_addr  (rd_ptr),
      .rd_pc    (rd_pc),
      .rd_instr (rd_instr)
   );

   // Present the head entry, or a zero PC and NOP bubble when empty.
   always_comb begin
      out_pc    = '0;
      out_instr = DATA_W'(NOP_INSTR);
      if (out_valid) begin
         out_pc    = rd_pc;
         out_instr = rd_instr;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=2, DATA_W=32).
module tb_if_id_queue;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        flush;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;
   logic [1:0]  count;

   int tests_run;
   int tests_failed;

   if_id_queue #(.DEPTH(2), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_ready (out_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_empty(input string tag);
      check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".out_pc"},    out_pc,             32'd0);
      check({tag, ".out_instr"}, out_instr,          32'd0);
      check({tag, ".count"},     {30'd0, count},     32'd0);
      check({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst       = 1'b0;
      in_valid  = 1'b1;
      in_pc     = 32'h0000_0100;
      in_instr  = 32'hDEAD_BEEF;
      flush     = 1'b0;
      out_ready = 1'b0;

      // Reset held two cycles with in_valid asserted: nothing stored.
      tick();
      tick();
      check_empty("reset");
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      check_empty("post_reset");

      // Single push, one-cycle latency.
      in_valid = 1'b1; in_pc = 32'd4; in_instr = 32'hE3A0_0001;
      tick();
      check("push1.out_valid", {31'd0, out_valid}, 32'd1);
      check("push1.out_pc",    out_pc,             32'd4);
      check("push1.out_instr", out_instr,          32'hE3A0_0001);
      check("push1.count",     {30'd0, count},     32'd1);

      // Fill to DEPTH.
      in_pc = 32'd8; in_instr = 32'hE3A0_0002;
      tick();
      check("fill.count",    {30'd0, count},    32'd2);
      check("fill.in_ready", {31'd0, in_ready}, 32'd0);
      check("fill.out_pc",   out_pc,            32'd4);

      // Push while full is ignored.
      in_pc = 32'd12; in_instr = 32'hE3A0_0003;
      tick();
      check("full_push.count",  {30'd0, count}, 32'd2);
      check("full_push.out_pc", out_pc,         32'd4);

      // Push still refused while full even with a same-cycle pop.
      out_ready = 1'b1;
      tick();
      check("full_pop.count",     {30'd0, count}, 32'd1);
      check("full_pop.out_pc",    out_pc,         32'd8);
      check("full_pop.out_instr", out_instr,      32'hE3A0_0002);

      // Drain: pc 12 must never show up.
      in_valid = 1'b0;
      tick();
      check_empty("drain");

      // Pop on empty is a no-op.
      tick();
      check_empty("pop_empty");

      // Simultaneous push and pop at count 1.
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'd4; in_instr = 32'hE3A0_0004;
      tick();
      check("sim_pre.out_pc", out_pc, 32'd4);
      out_ready = 1'b1;
      in_pc = 32'd8; in_instr = 32'hE3A0_0008;
      tick();
      check("sim.count",     {30'd0, count}, 32'd1);
      check("sim.out_pc",    out_pc,         32'd8);
      check("sim.out_instr", out_instr,      32'hE3A0_0008);
      in_valid = 1'b0;
      tick();
      check_empty("sim_drain");

      // Flush at count 2 with an incoming pair.
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'd4; in_instr = 32'hE3A0_0004;
      tick();
      in_pc = 32'd8; in_instr = 32'hE3A0_0008;
      tick();
      check("pre_flush.count", {30'd0, count}, 32'd2);
      flush = 1'b1;
      in_pc = 32'd12; in_instr = 32'hE3A0_000C;
      tick();
      check_empty("flush");
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      check_empty("post_flush");

      // Streaming through the wrap point with out_ready held high.
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_pc    = 32'(4 * (k + 1));
         in_instr = 32'hE1A0_0000 + 32'(k);
         tick();
         check($sformatf("wrap%0d.out_valid", k), {31'd0, out_valid}, 32'd1);
         check($sformatf("wrap%0d.out_pc", k),    out_pc,             32'(4 * (k + 1)));
         check($sformatf("wrap%0d.out_instr", k), out_instr,          32'hE1A0_0000 + 32'(k));
         check($sformatf("wrap%0d.count", k),     {30'd0, count},     32'd1);
      end
      in_valid = 1'b0;
      tick();
      check_empty("wrap_end");

      // Mid-stream reset loses everything, even with a flush pending.
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'd20; in_instr = 32'hE3A0_0014;
      tick();
      in_pc = 32'd24; in_instr = 32'hE3A0_0018;
      tick();
      check("pre_rst.count", {30'd0, count}, 32'd2);
      rst   = 1'b0;
      flush = 1'b1;
      tick();
      check_empty("mid_reset");
      rst      = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      check_empty("mid_reset_after");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between the instruction-fetch stage and the instruction-decode stage of the 5-stage ARM pipeline.
- Holds up to DEPTH {PC, instruction} pairs in FIFO order and presents the oldest pair to ID.
- Back-pressures IF through in_ready; IF freeze = !in_ready.
- Discards all held and incoming entries when a taken branch flushes the front end.

Parameters:
- DEPTH, 2, number of entries; must be a power of two and at least 2.
- DATA_W, 32, width of the PC and instruction fields.

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-low; state clears on a rising clk edge while rst==0.
- in_valid  input  1  IF presents a fetched pair this cycle.
- in_pc  input  DATA_W  PC+4 value from IF.
- in_instr  input  DATA_W  instruction word from IF.
- in_ready  output  1  queue accepts a push this cycle.
- flush  input  1  branch_taken from EXE; empties the queue.
- out_valid  output  1  head entry valid for ID.
- out_pc  output  DATA_W  head PC; 0 when empty.
- out_instr  output  DATA_W  head instruction; 0 (NOP bubble) when empty.
- out_ready  input  1  ID consumes the head this cycle; this is the inverse of the hazard freeze.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage:
  - Circular array of DEPTH entries.
  - Pointers wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally.
  - count is tracked separately and is never derived from the pointers.
- Push: in_valid && in_ready && !flush. Writes {in_pc, in_instr} at wr_ptr, then wr_ptr++.
- Pop: out_valid && out_ready && !flush. rd_ptr++.
- in_ready = (count < DEPTH). It is computed only from registered state; there is no combinational path from out_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- out_pc / out_instr are read combinationally from entry rd_ptr when out_valid=1, and forced to 0 otherwise.
- Latency: a pair pushed at edge N is visible at the outputs after edge N, i.e. one cycle. There is no bypass when empty.
- Occupancy per cycle:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged, data order preserved.
- Occupancy states, derived from count:
  - EMPTY (0): pop impossible.
  - PARTIAL (1..DEPTH-1): push and pop both legal.
  - FULL (DEPTH): push refused.
- Flush has priority over push and pop. On the next edge:
  - count=0, wr_ptr=rd_ptr=0.
  - The incoming pair in that cycle is discarded.
  - Storage contents need not be cleared.
- Reset (rst==0 at an edge):
  - count=0, pointers 0, all storage entries cleared to 0.
  - Outputs after reset: out_valid=0, out_pc=0, out_instr=0, in_ready=1, count=0.
  - Reset overrides flush, push and pop.
  - Reset applied mid-stream loses all entries with no partial state.
- in_pc / in_instr are ignored when in_valid=0. No X propagates to the outputs when empty.
- Popping when empty and pushing when full are no-ops; the pointers do not move.

Decomposition:
- Shared pipeline package holds:
  - DATA_W default (32).
  - NOP_INSTR constant (32'h0000_0000).
  - Function returning the count width, $clog2(DEPTH+1).
- One natural sub-module, if_id_storage: register array with one synchronous write port, one asynchronous read port, and synchronous active-low clear.
- Pointer/count control stays in if_id_queue.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_instr=0, count=0, in_ready=1; nothing stored.
- Single push: in_valid=1, in_pc=4, in_instr=E3A00001, out_ready=0 -> next cycle out_valid=1, out_pc=4, out_instr=E3A00001, count=1.
- Fill and order:
  - Push pc 4 then 8 with out_ready=0 -> count=2, in_ready=0.
  - Push of pc 12 is ignored.
  - Then out_ready=1 -> out_pc 4, then 8, then out_valid=0.
- Simultaneous push and pop at count=1 (head pc 4, push pc 8) -> count stays 1, next head pc 8.
- Flush at count=2 with in_valid=1 (pc 12) -> next cycle count=0, out_valid=0, in_ready=1; pc 12 never appears.
- Wrap: stream pc 4,8,...,40 (10 pairs) with out_ready=1 continuously -> outputs in exact order one per cycle after a 1-cycle latency, count never exceeds 1.
